instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decode/control path. Holds the PC, issues
//  word reads to instruction memory over a valid/ready request + response channel,
//  captures the returned word and presents it with pre-split opcode/funct3/funct7
//  fields to decode. Handles decode backpressure, branch/jump redirects and bus errors.
// PARAMETERS
//  XLEN      32            address/instruction width
//  RESET_PC  32'h0000_0000 PC loaded on reset
//  NOP_INSTR 32'h0000_0013 word presented on reset/fault (addi x0,x0,0)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  imem_req_valid out  1     read request valid
//  imem_req_addr  out  XLEN  word-aligned read address
//  imem_req_ready in   1     memory accepts request
//  imem_rsp_valid in   1     read data valid (exactly one per accepted request)
//  imem_rsp_data  in   XLEN  instruction word
//  imem_rsp_err   in   1     bus error, qualified by imem_rsp_valid
//  redirect_valid in   1     branch/jump taken, 1-cycle pulse
//  redirect_pc    in   XLEN  redirect target; bits [1:0] ignored (forced 0)
//  id_valid       out  1     instruction valid to decode
//  id_ready       in   1     decode accepts instruction
//  id_instr       out  XLEN  instruction word
//  id_pc          out  XLEN  PC of id_instr
//  id_opcode      out  7     id_instr[6:0]
//  id_funct3      out  3     id_instr[14:12]
//  id_funct7      out  7     id_instr[31:25]
//  id_fault       out  1     id_instr came from errored fetch
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, kill=0, imem_req_valid=0 while rst_n low,
//   id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_fault=0; fields follow id_instr.
//  All id_* outputs registered; imem_req_valid=(state==REQ), imem_req_addr=pc.
//  FSM (REQ, WAIT, HOLD):
//   REQ : on imem_req_ready -> WAIT. Response inputs ignored in REQ.
//   WAIT: on imem_rsp_valid & !kill & !redirect_valid: id_instr<=data (NOP_INSTR
//         if err), id_fault<=err, id_pc<=pc, id_valid<=1, pc<=pc+4, -> HOLD.
//         On imem_rsp_valid & (kill | redirect_valid): drop word, kill<=0, -> REQ.
//   HOLD: id_valid=1, all id_* stable while id_ready=0.
//         On id_ready: id_valid<=0, -> REQ (next request issued next cycle).
//  Redirect (highest priority), new pc = {redirect_pc[XLEN-1:2],2'b00}:
//   REQ without handshake: pc updated, addr changes next cycle, stay REQ.
//   REQ with handshake same cycle: pc updated, kill<=1, -> WAIT.
//   WAIT, no response: pc updated, kill<=1. WAIT with response: word dropped, -> REQ.
//   HOLD: id_valid<=0 even if id_ready=1, pc updated, -> REQ.
//  Throughput: 1 instr / 3 cycles with zero-wait memory. One outstanding request max.
//  pc+4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
//  Fault: no halt; fetch continues at pc+4; decode handles id_fault.
//  Reset mid-operation: immediate return to reset values; late responses for the
//   aborted request arrive in REQ and are ignored.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32),
//   reset 0, wrap at 2^32; fetch_cnt +1 per id_valid&id_ready, stall_cnt +1 per
//   cycle in HOLD with id_ready=0. Not defined: ports and counters absent, no logic.
// TESTING
//  Reset release, ready=1, 0-wait rsp -> req addrs 0x0,0x4,0x8; id_pc matches; 3-cycle cadence.
//  rsp 0x00500093 at 0x0 -> id_opcode=0x13, id_funct3=0, id_funct7=0, id_fault=0.
//  id_ready low 5 cycles in HOLD -> id_* stable, no new request; ready high -> req 0x4.
//  Redirect 0x103 in WAIT, rsp 2 cycles later -> word dropped, next req 0x100, id_pc=0x100.
//  rsp_err=1 at 0x8 -> id_instr=0x00000013, id_fault=1; next req 0xC.
//  rst_n low in WAIT, rsp after release -> ignored, first req 0x0; with IFU_PERF_CNT_EN
//   after 3 accepted + 5 stall cycles -> fetch_cnt=3, stall_cnt=5.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave):
// a valid/ready read request channel plus a single-beat response channel.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word read at a time over the
// imem bus, and presents the returned word (with pre-split decode fields) to decode.
// Handles decode backpressure, branch/jump redirects and bus errors.
// Optional feature macro: IFU_PERF_CNT_EN adds fetch/stall performance counters.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [XLEN-1:0]     id_instr,
  output logic [XLEN-1:0]     id_pc,
  output logic [6:0]          id_opcode,
  output logic [2:0]          id_funct3,
  output logic [6:0]          id_funct7,
  output logic                id_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    st_req  = 2'd0,
    st_wait = 2'd1,
    st_hold = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsb;

  // Redirect targets are always word aligned; the low bits are discarded.
  assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request is held off while reset is asserted even though the state already reads REQ.
  assign imem.imem_req_valid = rst_n && (state == st_req);
  assign imem.imem_req_addr  = pc;

  // Decode fields are slices of the registered instruction word.
  assign id_opcode = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

  // Fetch FSM: request, wait for the response, hold the word until decode takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= st_req;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
      id_fault <= 1'b0;
    end else begin
      case (state)
        st_req: begin
          // A redirect in the handshake cycle still lets the old request go out;
          // its response is marked for discard by kill.
          if (imem.imem_req_ready) begin
            state <= st_wait;
            kill  <= redirect_valid;
          end
          if (redirect_valid) pc <= redirect_target;
        end
        st_wait: begin
          if (imem.imem_rsp_valid) begin
            if (kill || redirect_valid) begin
              kill  <= 1'b0;
              state <= st_req;
              if (redirect_valid) pc <= redirect_target;
            end else begin
              id_instr <= imem.imem_rsp_err ? NOP_INSTR : imem.imem_rsp_data;
              id_fault <= imem.imem_rsp_err;
              id_pc    <= pc;
              id_valid <= 1'b1;
              pc       <= pc + XLEN'(4);
              state    <= st_hold;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_target;
            kill <= 1'b1;
          end
        end
        st_hold: begin
          if (redirect_valid) begin
            id_valid <= 1'b0;
            pc       <= redirect_target;
            state    <= st_req;
          end else if (id_ready) begin
            id_valid <= 1'b0;
            state    <= st_req;
          end
        end
        default: state <= st_req;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters: accepted instructions and decode-backpressure cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (id_valid && id_ready)              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == st_hold) && !id_ready)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level memory/decode model
// drives randomized traffic and predicts request addresses and presented instructions.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) imem();

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        id_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instr_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem(imem.master),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_opcode(id_opcode),
    .id_funct3(id_funct3),
    .id_funct7(id_funct7),
    .id_fault(id_fault)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the next request address is, whether a request is
  // outstanding (and whether it was cancelled), and what is shown to decode.
  logic [31:0] exp_addr;
  bit          out_valid, out_kill;
  logic [31:0] out_addr;
  int          lat;
  bit          pres_valid;
  logic [31:0] pres_instr, pres_pc;
  bit          pres_fault;
  int unsigned m_fetch, m_stall;
  int          cyc, last_hs;
  bit          cadence_mode;

  int unsigned p_ready, p_idready, max_lat, p_redir, p_err;

  task automatic model_reset();
    exp_addr   = 32'h0;
    out_valid  = 1'b0;
    out_kill   = 1'b0;
    out_addr   = 32'h0;
    lat        = 0;
    pres_valid = 1'b0;
    pres_instr = NOP;
    pres_pc    = 32'h0;
    pres_fault = 1'b0;
    m_fetch    = 0;
    m_stall    = 0;
    last_hs    = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem.imem_req_valid), 32'h0);
    check({tag, "_id_valid"},  32'(id_valid), 32'h0);
    check({tag, "_id_instr"},  id_instr, NOP);
    check({tag, "_id_pc"},     id_pc, 32'h0);
    check({tag, "_id_fault"},  32'(id_fault), 32'h0);
    check({tag, "_opcode"},    32'(id_opcode), 32'h13);
`ifdef IFU_PERF_CNT_EN
    check({tag, "_perf_fetch"}, perf_fetch_cnt, 32'h0);
    check({tag, "_perf_stall"}, perf_stall_cnt, 32'h0);
`endif
  endtask

  // Asserts reset mid-cycle, checks reset values, then releases it while a stale
  // response is on the bus (must be ignored; memory refuses the request that cycle).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    redirect_valid      = 1'b0;
    id_ready            = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst_n = 1'b1;
    imem.imem_rsp_valid = 1'b1;
    imem.imem_rsp_data  = 32'hDEAD_BEEF;
    imem.imem_rsp_err   = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_rel_req_valid", 32'(imem.imem_req_valid), 32'h1);
    check("rst_rel_req_addr",  imem.imem_req_addr, 32'h0);
    check("rst_rel_id_valid",  32'(id_valid), 32'h0);
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_err   = 1'b0;
  endtask

  task automatic step();
    bit          rdy, irdy, rsp, redir, err, hs, acc, exp_req;
    logic [31:0] data, tgt;
    @(negedge clk);
    cyc++;
    exp_req = !out_valid && !pres_valid;
    check("req_valid", 32'(imem.imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem.imem_req_addr, exp_addr);
    check("id_valid", 32'(id_valid), 32'(pres_valid));
    if (pres_valid) begin
      check("id_instr",  id_instr, pres_instr);
      check("id_pc",     id_pc, pres_pc);
      check("id_fault",  32'(id_fault), 32'(pres_fault));
      check("id_opcode", 32'(id_opcode), 32'(pres_instr[6:0]));
      check("id_funct3", 32'(id_funct3), 32'(pres_instr[14:12]));
      check("id_funct7", 32'(id_funct7), 32'(pres_instr[31:25]));
    end
`ifdef IFU_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, m_fetch);
    check("perf_stall", perf_stall_cnt, m_stall);
`endif

    rdy   = $urandom_range(99) < p_ready;
    irdy  = $urandom_range(99) < p_idready;
    redir = $urandom_range(99) < p_redir;
    rsp   = out_valid && (lat == 0);
    data  = $urandom;
    err   = $urandom_range(99) < p_err;
    if (rsp && out_addr == 32'h0) data = 32'h0050_0093;
    if (rsp && out_addr == 32'h8) err = 1'b1;
    case ($urandom_range(3))
      0:       tgt = 32'h0000_0103;
      1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      default: tgt = $urandom & 32'h0000_0FFF;
    endcase

    imem.imem_req_ready = rdy;
    imem.imem_rsp_valid = rsp;
    imem.imem_rsp_data  = data;
    imem.imem_rsp_err   = err;
    redirect_valid      = redir;
    redirect_pc         = tgt;
    id_ready            = irdy;

    hs  = exp_req && rdy;
    acc = pres_valid && irdy;
    if (pres_valid && !irdy) m_stall++;
    if (acc) m_fetch++;
    if (pres_valid && (acc || redir)) pres_valid = 1'b0;
    if (rsp) begin
      out_valid = 1'b0;
      if (!(out_kill || redir)) begin
        pres_valid = 1'b1;
        pres_instr = err ? NOP : data;
        pres_pc    = out_addr;
        pres_fault = err;
        exp_addr   = out_addr + 32'd4;
      end
    end else if (out_valid) begin
      lat--;
    end
    if (hs) begin
      out_valid = 1'b1;
      out_kill  = 1'b0;
      out_addr  = exp_addr;
      lat       = int'($urandom_range(max_lat));
      if (cadence_mode && last_hs >= 0) check("cadence", 32'(cyc - last_hs), 32'd3);
      last_hs = cyc;
    end
    if (redir) begin
      exp_addr = {tgt[31:2], 2'b00};
      if (out_valid) out_kill = 1'b1;
    end
  endtask

  initial begin
    bit found;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    imem.imem_rsp_err   = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    id_ready            = 1'b0;
    cyc                 = 0;
    model_reset();

    do_reset();

    // Zero-wait memory, decode always ready, no redirects: 3-cycle cadence.
    cadence_mode = 1'b1;
    p_ready = 100; p_idready = 100; max_lat = 0; p_redir = 0; p_err = 0;
    for (int i = 0; i < 30; i++) step();
    cadence_mode = 1'b0;

    // Decode backpressure held long enough to cover multi-cycle stalls.
    p_idready = 0;
    for (int i = 0; i < 8; i++) step();
    p_idready = 100;
    for (int i = 0; i < 6; i++) step();

    // Fully randomized traffic with redirects and bus errors.
    p_ready = 60; p_idready = 60; max_lat = 3; p_redir = 8; p_err = 10;
    for (int i = 0; i < 3000; i++) step();

    // Reset while a request is outstanding.
    p_ready = 100; p_idready = 100; max_lat = 4; p_redir = 0; p_err = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (out_valid && lat >= 1) found = 1'b1;
    end
    check("reach_wait", 32'(found), 32'h1);
    do_reset();

    p_ready = 70; p_idready = 50; max_lat = 2; p_redir = 5; p_err = 10;
    for (int i = 0; i < 500; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
